// File: rtl/dht11_emulator.sv
// DHT11 sensor emulator: answers a host start pulse with a 40-bit open-drain frame.
// Define DHT11_EMU_ERR_INJECT_EN to add err_inject, which inverts the sent checksum.
module dht11_emulator #(
    parameter int START_MIN = 1000,
    parameter int T_WAIT    = 30,
    parameter int T_RESP    = 80,
    parameter int T_BIT_LOW = 50,
    parameter int T_ZERO    = 26,
    parameter int T_ONE     = 70,
    parameter int T_EOF     = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    inout  wire        dht_data,
    input  logic [7:0] humidity_in,
    input  logic [7:0] temperature_in,
`ifdef DHT11_EMU_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [3:0] {
        IDLE,
        HOST_LOW,
        HOST_REL,
        RESP_WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        EOF_LOW
    } state_t;

    localparam logic [15:0] START_W  = 16'(START_MIN);
    localparam logic [15:0] WAIT_END = 16'(T_WAIT - 1);
    localparam logic [15:0] RESP_END = 16'(T_RESP - 1);
    localparam logic [15:0] BLOW_END = 16'(T_BIT_LOW - 1);
    localparam logic [15:0] ZERO_END = 16'(T_ZERO - 1);
    localparam logic [15:0] ONE_END  = 16'(T_ONE - 1);
    localparam logic [15:0] EOF_END  = 16'(T_EOF - 1);

    state_t      state;
    logic [1:0]  sync;
    logic        line_s;
    logic [15:0] cnt;
    logic [5:0]  bit_idx;
    logic [7:0]  hum_q;
    logic [7:0]  temp_q;
    logic        drive_low;
    logic [7:0]  cksum;
    logic [7:0]  cksum_tx;
    logic [39:0] frame;
    logic [5:0]  bit_pos;
    logic        cur_bit;
    logic [15:0] high_end;

`ifdef DHT11_EMU_ERR_INJECT_EN
    logic err_q;
    assign cksum_tx = err_q ? ~cksum : cksum;
`else
    assign cksum_tx = cksum;
`endif

    assign line_s   = sync[1];
    assign cksum    = hum_q + temp_q;
    assign frame    = {hum_q, 8'h00, temp_q, 8'h00, cksum_tx};
    assign bit_pos  = 6'd39 - bit_idx;
    assign cur_bit  = frame[bit_pos];
    assign high_end = cur_bit ? ONE_END : ZERO_END;
    assign dht_data = drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sync       <= 2'b11;
            cnt        <= '0;
            bit_idx    <= '0;
            hum_q      <= '0;
            temp_q     <= '0;
`ifdef DHT11_EMU_ERR_INJECT_EN
            err_q      <= 1'b0;
`endif
            drive_low  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sync       <= {sync[0], dht_data};
            frame_done <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                cnt       <= '0;
                bit_idx   <= '0;
                drive_low <= 1'b0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!line_s) begin
                            state <= HOST_LOW;
                            cnt   <= 16'd1;
                        end
                    end
                    HOST_LOW: begin
                        if (line_s) begin
                            cnt <= '0;
                            if (cnt >= START_W) begin
                                state <= HOST_REL;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (cnt != 16'hFFFF) begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    HOST_REL: begin
                        hum_q  <= humidity_in;
                        temp_q <= temperature_in;
`ifdef DHT11_EMU_ERR_INJECT_EN
                        err_q  <= err_inject;
`endif
                        state  <= RESP_WAIT;
                        cnt    <= '0;
                    end
                    RESP_WAIT: begin
                        if (cnt == WAIT_END) begin
                            state     <= RESP_LOW;
                            drive_low <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    RESP_LOW: begin
                        if (cnt == RESP_END) begin
                            state     <= RESP_HIGH;
                            drive_low <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    RESP_HIGH: begin
                        if (cnt == RESP_END) begin
                            state     <= BIT_LOW;
                            drive_low <= 1'b1;
                            cnt       <= '0;
                            bit_idx   <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    BIT_LOW: begin
                        if (cnt == BLOW_END) begin
                            state     <= BIT_HIGH;
                            drive_low <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    BIT_HIGH: begin
                        // high width encodes the bit value
                        if (cnt == high_end) begin
                            drive_low <= 1'b1;
                            cnt       <= '0;
                            if (bit_idx == 6'd39) begin
                                state <= EOF_LOW;
                            end else begin
                                state   <= BIT_LOW;
                                bit_idx <= bit_idx + 6'd1;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    EOF_LOW: begin
                        if (cnt == EOF_END) begin
                            state      <= IDLE;
                            drive_low  <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            cnt        <= '0;
                            bit_idx    <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        drive_low <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dht11_emulator.md
DHT11_EMULATOR -- requirements
Module: dht11_emulator

Interface
REQ-001 Parameter START_MIN, default 1000: minimum host low pulse, in clk cycles, accepted as a start request.
REQ-002 Parameters and defaults, all in clk cycles:
- T_WAIT, 30
- T_RESP, 80
- T_BIT_LOW, 50
- T_ZERO, 26
- T_ONE, 70
- T_EOF, 50
REQ-003 clk  input  1  system clock, 1 MHz (1 cycle = 1 us).
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  emulator enable; low = idle and line released.
REQ-006 dht_data  inout  1  open-drain single-wire bus; the block only drives 0 or z, and an external pull-up supplies high.
REQ-007 humidity_in  input  8  humidity integer byte to transmit.
REQ-008 temperature_in  input  8  temperature integer byte to transmit.
REQ-009 busy  output  1  high from start-request detection until frame end.
REQ-010 frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 dht_data shall be sampled through a 2-flop synchronizer, called line_s below; all decisions shall use line_s.
REQ-012 The state machine shall have these states: IDLE, HOST_LOW, HOST_REL, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, EOF_LOW.
REQ-013 IDLE -> HOST_LOW when line_s==0; the low-cycle counter shall start at 1.
REQ-014 HOST_LOW shall count while line_s==0, saturating at 2^16-1.
- On line_s==1 with count >= START_MIN: go to HOST_REL.
- On line_s==1 with count < START_MIN: return to IDLE with no response.
REQ-015 HOST_REL shall latch humidity_in and temperature_in and go to RESP_WAIT.
REQ-016 The latched frame shall be {hum, 8'h00, temp, 8'h00, cksum}, sent MSB first, with cksum = (hum + 8'h00 + temp + 8'h00) mod 256.
REQ-017 RESP_WAIT shall release the line for T_WAIT cycles.
REQ-018 RESP_LOW shall drive 0 for T_RESP cycles; RESP_HIGH shall then release for T_RESP cycles.
REQ-019 Each bit shall be T_BIT_LOW cycles driven 0 (BIT_LOW), then released for T_ZERO cycles (bit 0) or T_ONE cycles (bit 1) (BIT_HIGH).
REQ-020 After bit 39, EOF_LOW shall drive 0 for T_EOF cycles, then release, pulse frame_done, and return to IDLE.
REQ-021 The block shall drive 0 only in RESP_LOW, BIT_LOW and EOF_LOW, and release the line in every other state.
REQ-022 busy shall be 1 in all states from HOST_REL through EOF_LOW inclusive, and 0 otherwise.
REQ-023 A bit counter of 0..39 shall be used; on completion of bit 39 it shall not wrap and shall exit to EOF_LOW.
REQ-024 Line activity while busy shall be ignored; the frame shall run to completion with no re-arming.
REQ-025 en low in any state shall, on the next edge, release the line, go to IDLE, clear counters and hold frame_done at 0; no frame_done shall be issued for an aborted frame.
REQ-026 en rising while line_s==0 shall enter HOST_LOW with count 1; a partial pulse shall be measured only from that point.

Reset
REQ-027 rst_n low shall immediately release dht_data and set:
- state = IDLE
- busy = 0
- frame_done = 0
- counters = 0
- latched bytes = 0
- synchronizer flops = 1
REQ-028 Reset asserted mid-frame shall abandon the frame; after reset release, the block shall wait for a fresh start request.

Configuration
REQ-029 Macro DHT11_EMU_ERR_INJECT_EN, when defined, shall add input port err_inject (1 bit), latched in HOST_REL; if it is latched as 1, the transmitted checksum shall be ~cksum.
REQ-030 Without DHT11_EMU_ERR_INJECT_EN, the err_inject port shall not exist and the checksum shall always be correct.

Verification
REQ-031 hum=0x37, temp=0x19, host low 18000 cycles then release -> after T_WAIT, 80 low / 80 high; bytes 37 00 19 00 50; frame_done after EOF; busy low after.
REQ-032 Host low 500 cycles -> line never driven; busy stays 0.
REQ-033 hum=0xC8, temp=0x64 -> checksum byte 0x2C (wrap-around); high widths 26 us for 0 bits and 70 us for 1 bits, each +/-0 cycles.
REQ-034 en dropped at bit 12 -> line released the next cycle; no frame_done; a new 18000-cycle start yields a full valid frame.
REQ-035 DHT11_EMU_ERR_INJECT_EN defined, err_inject=1, hum=0x37, temp=0x19 -> checksum byte 0xAF; with err_inject=0 -> 0x50.
REQ-036 rst_n pulsed low during RESP_LOW -> dht_data goes z asynchronously; busy=0; no further activity until the next start request.
